// File: rtl/cardinal_nic_mq_pkg.sv
// cardinal_nic_mq_pkg: register address codes, VC bit index and status field widths shared by the NIC and its benches
package cardinal_nic_mq_pkg;
  typedef enum logic [1:0] {
    ADDR_RD_IN  = 2'b00,
    ADDR_ST_IN  = 2'b01,
    ADDR_WR_OUT = 2'b10,
    ADDR_ST_OUT = 2'b11
  } addr_e;
  localparam int VC_BIT = 0;
  localparam int CNT_W = 8;
endpackage

// File: rtl/cardinal_nic_mq_fifo.sv
// nic_fifo: circular FIFO with occupancy count; a full FIFO rejects pushes even when popped in the same cycle
module nic_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/cardinal_nic_mq.sv
// cardinal_nic_mq: PE/ring NIC with an input FIFO and per-VC output FIFOs selected by router polarity
module cardinal_nic_mq
  import cardinal_nic_mq_pkg::*;
#(
  parameter int PACKET_SIZE = 64,
  parameter int IN_DEPTH = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [0:1]             addr,
  input  logic [0:PACKET_SIZE-1] d_in,
  output logic [0:PACKET_SIZE-1] d_out,
  input  logic                   nicEn,
  input  logic                   nicEnWr,
  input  logic                   net_si,
  output logic                   net_ri,
  input  logic [0:PACKET_SIZE-1] net_di,
  output logic                   net_so,
  input  logic                   net_ro,
  output logic [0:PACKET_SIZE-1] net_do,
  input  logic                   net_polarity
);
  localparam int IW = $clog2(IN_DEPTH + 1);
  localparam int OW = $clog2(OUT_DEPTH + 1);
  addr_e a;
  logic rd_in, st_in_rd, wr_out, st_out_rd, vc, drop_now, drop;
  logic in_full, in_empty, vc0_full, vc0_empty, vc1_full, vc1_empty;
  logic [IW-1:0] in_cnt;
  logic [OW-1:0] vc0_cnt, vc1_cnt;
  logic [PACKET_SIZE-1:0] in_head, vc0_head, vc1_head, st_in, st_out;
  assign a = addr_e'(addr);
  assign rd_in = nicEn & ~nicEnWr & (a == ADDR_RD_IN);
  assign st_in_rd = nicEn & ~nicEnWr & (a == ADDR_ST_IN);
  assign wr_out = nicEn & nicEnWr & (a == ADDR_WR_OUT);
  assign st_out_rd = nicEn & ~nicEnWr & (a == ADDR_ST_OUT);
  assign vc = d_in[VC_BIT];
  assign drop_now = wr_out & (vc ? vc1_full : vc0_full);
  assign net_ri = ~reset & ~in_full;
  assign net_so = ~reset & net_ro & (net_polarity ? ~vc0_empty : ~vc1_empty);
  assign net_do = net_polarity ? (vc0_empty ? '0 : vc0_head) : (vc1_empty ? '0 : vc1_head);
  // Status words are built LSB-first, so the last d_out bit is the nonempty/vc0_full flag
  assign st_in = PACKET_SIZE'({CNT_W'(in_cnt), in_full, ~in_empty});
  assign st_out = PACKET_SIZE'({CNT_W'(vc1_cnt), CNT_W'(vc0_cnt), drop, vc1_full, vc0_full});
  always_comb
    d_out = rd_in ? (in_empty ? '0 : in_head) :
            st_in_rd ? st_in :
            st_out_rd ? st_out : '0;
  // A drop in the same cycle as a status read keeps the flag set
  always_ff @(posedge clk or posedge reset)
    if (reset) drop <= 1'b0;
    else drop <= drop_now | (drop & ~st_out_rd);
  nic_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(IN_DEPTH)) u_in (
    .clk(clk), .rst(reset), .push(net_si & net_ri), .pop(rd_in), .din(net_di),
    .head(in_head), .full(in_full), .empty(in_empty), .count(in_cnt)
  );
  nic_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(OUT_DEPTH)) u_vc0 (
    .clk(clk), .rst(reset), .push(wr_out & ~vc), .pop(net_so & net_polarity), .din(d_in),
    .head(vc0_head), .full(vc0_full), .empty(vc0_empty), .count(vc0_cnt)
  );
  nic_fifo #(.WIDTH(PACKET_SIZE), .DEPTH(OUT_DEPTH)) u_vc1 (
    .clk(clk), .rst(reset), .push(wr_out & vc), .pop(net_so & ~net_polarity), .din(d_in),
    .head(vc1_head), .full(vc1_full), .empty(vc1_empty), .count(vc1_cnt)
  );
endmodule
